// File: rtl/kb_event_decoder.sv
// PS/2 scan-byte decoder: E0/F0 prefix FSM feeding a first-word-fall-through event FIFO.
// Optional repeat suppression of held keys is built when KB_TYPEMATIC_FILTER_EN is defined.
module kb_event_decoder #(
  parameter int W_SIZE = 2,
  parameter int MODE   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_valid,
  input  logic [7:0] scan_byte,
  input  logic       rd_event,
  output logic [7:0] event_code,
  output logic       event_brk,
  output logic       event_ext,
  output logic       buf_empty,
  output logic       buf_full,
  output logic       overflow,
  input  logic       clr_overflow
);

  localparam int DEPTH = 1 << W_SIZE;
  localparam logic [W_SIZE:0] PTR_ONE = {{W_SIZE{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t state, state_nxt;
  logic   is_e0, is_f0;
  logic   dec_vld, dec_brk, dec_ext;
  logic   mode_ok, suppress, wr_req, wr_en, rd_en, drop;

  logic [9:0]      mem [DEPTH];
  logic [W_SIZE:0] wr_ptr, rd_ptr;

  assign is_e0 = (scan_byte == 8'hE0);
  assign is_f0 = (scan_byte == 8'hF0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (scan_valid) begin
      case (state)
        IDLE:    state_nxt = is_e0 ? EXT : (is_f0 ? BRK : IDLE);
        EXT:     state_nxt = is_f0 ? EXT_BRK : (is_e0 ? EXT : IDLE);
        default: state_nxt = IDLE;  // break states end on any byte; E0/F0 there is a protocol error
      endcase
    end
  end

  always_comb begin
    dec_vld = scan_valid && !is_e0 && !is_f0;
    dec_brk = (state == BRK) || (state == EXT_BRK);
    dec_ext = (state == EXT) || (state == EXT_BRK);
  end

  always_comb begin
    mode_ok = (MODE == 2) || ((MODE == 0) && !dec_brk) || ((MODE == 1) && dec_brk);
  end

`ifdef KB_TYPEMATIC_FILTER_EN
  logic [8:0] held;
  logic       held_vld;
  logic       held_match;

  assign held_match = held_vld && (held == {dec_ext, scan_byte});
  assign suppress   = dec_vld && !dec_brk && held_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      held_vld <= 1'b0;
    end else if (dec_vld) begin
      if (dec_brk && held_match)        held_vld <= 1'b0;
      else if (!dec_brk && !held_match) held_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (dec_vld && !dec_brk && !held_match) held <= {dec_ext, scan_byte};
  end
`else
  assign suppress = 1'b0;
`endif

  // FIFO: extra pointer MSB distinguishes full from empty when the indices coincide
  assign buf_empty = (wr_ptr == rd_ptr);
  assign buf_full  = (wr_ptr[W_SIZE] != rd_ptr[W_SIZE]) &&
                     (wr_ptr[W_SIZE-1:0] == rd_ptr[W_SIZE-1:0]);

  assign wr_req = dec_vld && mode_ok && !suppress && !reset;
  assign rd_en  = rd_event && !buf_empty;
  assign wr_en  = wr_req && (!buf_full || rd_event);
  assign drop   = wr_req && buf_full && !rd_event;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[W_SIZE-1:0]] <= {dec_brk, dec_ext, scan_byte};
  end

  assign {event_brk, event_ext, event_code} = mem[rd_ptr[W_SIZE-1:0]];

endmodule

// File: doc/kb_event_decoder.md
KB_EVENT_DECODER -- requirements
Module: kb_event_decoder

Interface
REQ-001 Parameter W_SIZE, default 2: the event FIFO holds 2^W_SIZE entries; legal range is 1..6.
REQ-002 Parameter MODE, default 2: 0 = make events only, 1 = break events only, 2 = both make and break events.
REQ-003 Port clk, input, 1: the single clock; every register updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port scan_valid, input, 1: one-cycle strobe meaning scan_byte holds a newly received PS/2 byte.
REQ-006 Port scan_byte, input, 8: the received scan byte; it is sampled only when scan_valid=1.
REQ-007 Port rd_event, input, 1: pops the FIFO head.
REQ-008 Port event_code, output, 8: final scan code of the head event.
REQ-009 Port event_brk, output, 1: head event is a break (key release).
REQ-010 Port event_ext, output, 1: head event carried the E0 extended prefix.
REQ-011 Port buf_empty, output, 1: FIFO is empty.
REQ-012 Port buf_full, output, 1: FIFO is full.
REQ-013 Port overflow, output, 1: sticky flag; at least one event was dropped because the FIFO was full.
REQ-014 Port clr_overflow, input, 1: clears overflow.

Function
REQ-015 The prefix FSM has four states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen).
REQ-016 In IDLE: E0 moves to EXT; F0 moves to BRK; any other byte emits make {ext=0, code}.
REQ-017 In EXT: F0 moves to EXT_BRK; E0 stays in EXT; any other byte emits make {ext=1, code} and returns to IDLE.
REQ-018 In BRK: any byte other than E0/F0 emits break {ext=0, code} and returns to IDLE; E0 or F0 is a protocol error: the byte is discarded, nothing is emitted, and the FSM returns to IDLE.
REQ-019 In EXT_BRK: any byte other than E0/F0 emits break {ext=1, code} and returns to IDLE; E0 or F0 is handled as in REQ-018.
REQ-020 The FSM changes state only in cycles where scan_valid=1.
REQ-021 MODE filters emission: an event whose type is excluded is not written, but the FSM still advances.
REQ-022 An emitted event is written to the FIFO on the clock edge that samples its final byte; buf_empty deasserts in the following cycle.
REQ-023 The FIFO is first-word-fall-through: event_code, event_brk and event_ext show the head combinationally while buf_empty=0; while buf_empty=1 their values are don't-care.
REQ-024 rd_event while empty is ignored, and the read pointer does not move.
REQ-025 An emit while full with rd_event=0: the event is dropped and overflow is set on the next edge.
REQ-026 An emit while full with rd_event=1: the read and the write both complete, the occupancy stays full, and overflow is unchanged.
REQ-027 An emit while empty with rd_event=1: only the write completes.
REQ-028 Pointers wrap modulo 2^W_SIZE; full and empty are decoded from the pointers plus a wrap bit.
REQ-029 If clr_overflow and a new drop occur in the same cycle, overflow is 1 afterwards (set wins).

Reset
REQ-030 On reset the FSM goes to IDLE, both pointers go to 0, and overflow goes to 0; after the edge buf_empty=1 and buf_full=0.
REQ-031 Reset asserted mid-prefix (EXT, BRK or EXT_BRK) discards the partial sequence; scan_valid in the reset cycle is ignored.
REQ-032 The typematic filter state (REQ-033) clears on reset.

Configuration
REQ-033 With KB_TYPEMATIC_FILTER_EN defined: a register holds the last accepted make {ext, code} plus a valid bit. A make equal to the held value while valid is suppressed. A break matching the held value clears valid. Any other make replaces the held value. The FSM still advances on every byte.
REQ-034 With KB_TYPEMATIC_FILTER_EN undefined: no filter register exists and every make allowed by MODE is written.

Verification
REQ-035 MODE=2, bytes 1C, F0, 1C -> two entries: {brk0, ext0, 1C} then {brk1, ext0, 1C}.
REQ-036 MODE=2, bytes E0, 75, E0, F0, 75 -> two entries: {0, 1, 75} then {1, 1, 75}.
REQ-037 MODE=0, bytes F0, 1C, 23 -> a single entry {0, 0, 23}.
REQ-038 W_SIZE=1, three makes 15, 1D, 24 with no reads -> FIFO holds 15 and 1D, buf_full=1, overflow=1; clr_overflow -> 0.
REQ-039 Full FIFO with rd_event and a make 2D in the same cycle -> head advances, 2D is written, buf_full stays 1, overflow stays 0.
REQ-040 Filter enabled, bytes 1C, 1C, 1C, F0, 1C, 1C -> three entries: make 1C, break 1C, make 1C. Filter disabled -> six bytes yield five entries.
